// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and map helpers for the 4x4 keypad scanner
package keypad_pkg;
    localparam int KEY_W = 4;
    localparam int MAP_W = 16;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;
    localparam logic [0:3][3:0] ROW_PAT = {4'hE, 4'hD, 4'hB, 4'h7};

    function automatic logic is_onehot0(input logic [MAP_W-1:0] m);
        return (m & (m - MAP_W'(1))) == '0;
    endfunction

    function automatic logic is_onehot(input logic [MAP_W-1:0] m);
        return (m != '0) && is_onehot0(m);
    endfunction

    function automatic logic [KEY_W-1:0] map_index(input logic [MAP_W-1:0] m);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAP_W; i++)
            if (m[i]) r = KEY_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a frame map once it has repeated DEBOUNCE_FRAMES times in a row
module keypad_debounce #(
    parameter int MAP_W = 16,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_end,
    input  logic [MAP_W-1:0] map,
    output logic [MAP_W-1:0] deb_map
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES - 1);

    logic [MAP_W-1:0] prev_raw;
    logic [CW-1:0]    stable_cnt, cnt_nxt;

    always_comb
        cnt_nxt = (map != prev_raw) ? '0 : (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw   <= '0;
            stable_cnt <= '0;
            deb_map    <= '0;
        end else if (frame_end) begin
            prev_raw   <= map;
            stable_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) deb_map <= map;
        end
    end
endmodule

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4: 4x4 matrix keypad scanner with frame debounce; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scan4x4
    import keypad_pkg::*;
#(
    parameter int CLK_HZ          = 12_000_000,
    parameter int SCAN_HZ         = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       kp_col,
    output logic [3:0]       kp_row,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);
    localparam int TICK_DIV = CLK_HZ / (SCAN_HZ * 4);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    if (DEBOUNCE_FRAMES < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
        $error("keypad_scan4x4: invalid DEBOUNCE_FRAMES/REPEAT_* parameters");
    end

    logic [TW-1:0]    tick_cnt;
    logic [1:0]       idx, state;
    logic [3:0]       col_s1, col_s2;
    logic [MAP_W-1:0] raw, cur_map, deb_map, hold_map;
    logic             tick, frame_end, eval, rep_hit;

    assign tick      = tick_cnt == TW'(TICK_DIV - 1);
    assign frame_end = tick && idx == 2'd3;
    assign hold_map  = MAP_W'(1) << key_code;

    always_comb begin
        cur_map = raw;
        cur_map[idx*4 +: 4] = ~col_s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            idx      <= '0;
            kp_row   <= 4'hF;
            col_s1   <= 4'hF;
            col_s2   <= 4'hF;
            raw      <= '0;
            eval     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            idx      <= tick ? idx + 2'd1 : idx;
            kp_row   <= ROW_PAT[idx];
            col_s1   <= kp_col;
            col_s2   <= col_s1;
            raw      <= tick ? cur_map : raw;
            eval     <= frame_end;
        end
    end

    keypad_debounce #(.MAP_W(MAP_W), .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
        .clk      (clk),
        .rst      (rst),
        .frame_end(frame_end),
        .map      (cur_map),
        .deb_map  (deb_map)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_cnt;
    logic          holding;
    assign holding = state == S_HOLD && deb_map == hold_map;
    assign rep_hit = holding && (rep_cnt + RW'(1) == RW'(REPEAT_DELAY));
    // Rewinding by REPEAT_RATE after each hit makes later hits land every REPEAT_RATE frames
    always_ff @(posedge clk) begin
        if (rst) rep_cnt <= '0;
        else if (eval) rep_cnt <= !holding ? '0 : rep_hit ? RW'(REPEAT_DELAY - REPEAT_RATE) : rep_cnt + RW'(1);
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (eval) begin
                if (state == S_IDLE) begin
                    if (deb_map != '0) begin
                        state <= is_onehot(deb_map) ? S_HOLD : S_LOCK;
                        if (is_onehot(deb_map)) begin
                            key_code  <= map_index(deb_map);
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                        end
                    end
                end else if (state == S_HOLD) begin
                    if (deb_map != hold_map) begin
                        state    <= (deb_map == '0) ? S_IDLE : S_LOCK;
                        key_down <= 1'b0;
                    end else begin
                        key_valid <= rep_hit;
                    end
                end else if (deb_map == '0) begin
                    state <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb_keypad_scan4x4: directed scoreboard bench for keypad_scan4x4 (honours KEYPAD_REPEAT_EN)
module tb_keypad_scan4x4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  kp_col, kp_row, key_code;
    logic        key_valid, key_down;
    logic [15:0] pressed = '0;

    int          errors = 0;
    int          checks = 0;
    int          rd = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  vcodes[$];
    int          vtimes[$];
    int          cyc = 0;
    int          long_cnt = 0;
    logic        kv_q = 1'b0;
    logic [3:0]  pat[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    keypad_scan4x4 #(
        .CLK_HZ(16000), .SCAN_HZ(1000), .DEBOUNCE_FRAMES(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .kp_col(kp_col), .kp_row(kp_row),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // Keypad model: a closed switch pulls its column low while its row is driven low
    always_comb begin
        kp_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp_row[r] && pressed[r*4+c]) kp_col[c] = 1'b0;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        kv_q <= key_valid;
        if (key_valid) begin
            vcodes.push_back(key_code);
            vtimes.push_back(cyc);
        end
        if (key_valid && kv_q) long_cnt <= long_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        int n = 0;
        logic [3:0] e;
        e = exp_q.pop_front();
        while (vcodes.size() <= rd && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (vcodes.size() <= rd) begin
            checks++;
            errors++;
            $error("FAIL %s: no key_valid within %0d clk, expected code %0h", tag, budget, e);
        end else begin
            chk(tag, 32'(vcodes[rd]), 32'(e));
            rd++;
        end
    endtask

    task automatic wait_up(input string tag);
        int n = 0;
        while (key_down && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(key_down), 0);
    endtask

    task automatic settle(input string tag);
        repeat (96) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
        rd = vcodes.size();
`else
        chk(tag, vcodes.size(), rd);
`endif
    endtask

    initial begin
        // 1: reset, then idle scanning
        repeat (3) @(negedge clk);
        chk("rst kp_row", 32'(kp_row), 32'hF);
        chk("rst key_code", 32'(key_code), 0);
        chk("rst key_valid", 32'(key_valid), 0);
        chk("rst key_down", 32'(key_down), 0);
        rst = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            chk("idle kp_row", 32'(kp_row), 32'(pat[((k - 1) / 4) % 4]));
        end
        chk("idle no key_valid", vcodes.size(), 0);
        chk("idle key_down", 32'(key_down), 0);

        // 2: single press of code 9 (row 2, col 1)
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_pulse("press9 code", 66);
        chk("press9 key_down", 32'(key_down), 1);
        repeat (112) @(negedge clk);
`ifndef KEYPAD_REPEAT_EN
        chk("press9 single pulse", vcodes.size(), rd);
`endif
        pressed = '0;
        repeat (32) @(negedge clk);
        chk("press9 down held after release", 32'(key_down), 1);
        wait_up("press9 key_down release");
        settle("press9 no pulse on release");

        // 3: bouncing key 5, then stable
        for (int i = 0; i < 6; i++) begin
            pressed[5] = ~pressed[5];
            repeat (6) @(negedge clk);
        end
        pressed[5] = 1'b1;
        exp_q.push_back(4'd5);
        wait_pulse("bounce5 code", 66);
        repeat (16) @(negedge clk);
        pressed = '0;
        wait_up("bounce5 release");
        settle("bounce5 single pulse");

        // 4: multi-key lockout
        pressed[0] = 1'b1;
        pressed[15] = 1'b1;
        repeat (128) @(negedge clk);
        chk("multi no pulse", vcodes.size(), rd);
        chk("multi key_down", 32'(key_down), 0);
        pressed[15] = 1'b0;
        repeat (128) @(negedge clk);
        chk("lock no pulse", vcodes.size(), rd);
        pressed = '0;
        repeat (96) @(negedge clk);
        pressed[3] = 1'b1;
        exp_q.push_back(4'd3);
        wait_pulse("after lock code3", 66);
        pressed = '0;
        wait_up("code3 release");
        settle("code3 single pulse");

        // 5: reset while key 7 is held
        pressed[7] = 1'b1;
        exp_q.push_back(4'd7);
        wait_pulse("hold7 code", 66);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst kp_row", 32'(kp_row), 32'hF);
        chk("midrst key_code", 32'(key_code), 0);
        chk("midrst key_valid", 32'(key_valid), 0);
        chk("midrst key_down", 32'(key_down), 0);
        rst = 1'b0;
        exp_q.push_back(4'd7);
        wait_pulse("reemit7 code", 66);
        chk("reemit7 key_down", 32'(key_down), 1);
        pressed = '0;
        wait_up("reemit7 release");
        settle("reemit7 single pulse");

        // 6: long hold of key 12
        pressed[12] = 1'b1;
        exp_q.push_back(4'd12);
        wait_pulse("hold12 code", 66);
`ifdef KEYPAD_REPEAT_EN
        for (int j = 1; j <= 4; j++) begin
            exp_q.push_back(4'd12);
            wait_pulse("repeat12 code", 96);
            if (rd > 1 && vtimes.size() >= rd)
                chk("repeat12 spacing", 32'(vtimes[rd-1] - vtimes[rd-2]), (j == 1) ? 80 : 32);
        end
        repeat (16) @(negedge clk);
`else
        repeat (192) @(negedge clk);
        chk("hold12 no repeat", vcodes.size(), rd);
`endif
        pressed = '0;
        wait_up("hold12 release");
        settle("hold12 tail");

        chk("key_valid one clk wide", long_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
